amci_arbiter: RTL and testbench
===============================

// Module: amci_arbiter
// PURPOSE
//  Shares one AXI4 no-burst master's AMCI command interface among NUM_REQ requesters.
//  Write and read channels are arbitrated independently, each round-robin.
//  Each channel latches the winner's command and pulses AMCI_WRITE / AMCI_READ.
//  It then waits for AMCI_WIDLE / AMCI_RIDLE and returns the response to the winner only.
//  Sits between the bridge front-ends (local and Aurora-side) and the AXI master.
// PARAMETERS
//  NUM_REQ         2   number of requesters (2..8)
//  AXI_DATA_WIDTH  32  AMCI data width, bits
//  AXI_ADDR_WIDTH  32  AMCI address width, bits
// PORTS  (vectors flattened; requester i occupies slice [i*W +: W])
//  clk           in   1            clock
//  resetn        in   1            async active-low reset
//  req_wreq      in   NUM_REQ      level write request, per requester
//  req_waddr     in   NUM_REQ*AW   write address
//  req_wdata     in   NUM_REQ*DW   write data
//  req_wsize     in   NUM_REQ*3    log2 write bytes
//  req_wdone     out  NUM_REQ      one-cycle one-hot write-complete pulse
//  req_wresp     out  2            BRESP of the completed write
//  req_rreq      in   NUM_REQ      level read request
//  req_raddr     in   NUM_REQ*AW   read address
//  req_rsize     in   NUM_REQ*3    log2 read bytes
//  req_rdone     out  NUM_REQ      one-cycle one-hot read-complete pulse
//  req_rdata     out  DW           read data (right-justified, from AMCI)
//  req_rresp     out  2            RRESP of the completed read
//  AMCI_WADDR/WDATA/WSIZE/WRITE  out  AW/DW/3/1   to master
//  AMCI_WRESP  in 2; AMCI_WIDLE  in 1             from master
//  AMCI_RADDR/RSIZE/READ         out  AW/3/1      to master
//  AMCI_RDATA  in DW; AMCI_RRESP in 2; AMCI_RIDLE in 1
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0; both FSMs go to IDLE.
//   Both last-grant pointers = NUM_REQ-1, so requester 0 wins first.
//  Clock edges only; all outputs are registered. The write FSM is described below.
//   The read FSM is identical, with r/READ/RIDLE/RDATA substituted.
//  IDLE: if |req_wreq && AMCI_WIDLE, grant the first set bit searching from (last+1) mod NUM_REQ.
//   Latch AMCI_WADDR/WDATA/WSIZE from the granted slice.
//   Set AMCI_WRITE=1 and last=grant, then go to WAIT.
//  WAIT: AMCI_WRITE=0 (a one-cycle pulse).
//   When AMCI_WRITE==0 && AMCI_WIDLE: req_wdone[grant]=1, req_wresp=AMCI_WRESP, go to DONE.
//  DONE: req_wdone=0, go to IDLE. req_wreq is not sampled in DONE.
//   This gives the requester one cycle to drop req_wreq after seeing done.
//  Latency: req_wreq high in cycle 0 (FSM idle) -> AMCI_WRITE high in cycle 1.
//   req_wdone is high the cycle after the master returns idle.
//  Requester contract: hold req_wreq and its fields stable until req_wdone.
//   Deassert req_wreq on the clock it sees req_wdone; re-asserting later is a new request.
//  Withdrawal: dropping req_wreq before grant is allowed; no done is issued.
//   Dropping it after grant is ignored: the transaction completes and done still pulses.
//  Fairness: under continuous requests, grants rotate 0,1,..,NUM_REQ-1,0.
//   No requester waits more than NUM_REQ-1 transactions.
//  Write and read FSMs are fully concurrent.
//   One requester may hold a write grant and a read grant at the same time.
//  req_wresp and req_rdata/req_rresp hold their values until the next completion.
//  Reset mid-transaction: abandon immediately. The master shares resetn, so no cleanup is needed.
// TESTING
//  1 Single write: req_wreq=01, waddr0=0x1000, wdata0=0xDEADBEEF, wsize0=2.
//    -> AMCI_WRITE one-cycle pulse in cycle 1 carrying those fields.
//    -> req_wdone=01 for one cycle after AMCI_WIDLE rises; req_wresp=BRESP (0).
//  2 Contention: req_wreq=11 asserted together, NUM_REQ=2, held after done.
//    -> grants in order 0,1,0,1; each done is one-hot; no back-to-back duplicate grant.
//  3 Concurrency: requester 0 reads 0x2000 while requester 1 writes 0x3000.
//    -> AMCI_READ and AMCI_WRITE overlap.
//    -> req_rdone=01 with req_rdata = slave data (e.g. 0x12345678); req_wdone=10.
//  4 Error: slave returns RRESP=2 on a read from requester 1 -> req_rdone=10, req_rresp=2.
//  5 Withdrawal: req_wreq0 pulses for one cycle while the write FSM is in WAIT for requester 1.
//    -> no grant to requester 0; only req_wdone=10 is issued.
//  6 Reset in WAIT: resetn=0 for 3 cycles -> all outputs 0.
//    -> the next request from requester 0 is granted first.

Source files
------------

// File: rtl/amci_arbiter.sv
// amci_arbiter: shares one AXI4 no-burst master's AMCI command port among
// NUM_REQ requesters. The write and read channels each run their own
// round-robin arbiter and three-state FSM (IDLE -> WAIT -> DONE).
// Every output is registered. Completion status is returned only to the
// requester that was granted.
module amci_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                resetn,
  // write requesters
  input  logic [NUM_REQ-1:0]                  req_wreq,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_waddr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*3-1:0]                req_wsize,
  output logic [NUM_REQ-1:0]                  req_wdone,
  output logic [1:0]                          req_wresp,
  // read requesters
  input  logic [NUM_REQ-1:0]                  req_rreq,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_raddr,
  input  logic [NUM_REQ*3-1:0]                req_rsize,
  output logic [NUM_REQ-1:0]                  req_rdone,
  output logic [AXI_DATA_WIDTH-1:0]           req_rdata,
  output logic [1:0]                          req_rresp,
  // AMCI write command side
  output logic [AXI_ADDR_WIDTH-1:0]           AMCI_WADDR,
  output logic [AXI_DATA_WIDTH-1:0]           AMCI_WDATA,
  output logic [2:0]                          AMCI_WSIZE,
  output logic                                AMCI_WRITE,
  input  logic [1:0]                          AMCI_WRESP,
  input  logic                                AMCI_WIDLE,
  // AMCI read command side
  output logic [AXI_ADDR_WIDTH-1:0]           AMCI_RADDR,
  output logic [2:0]                          AMCI_RSIZE,
  output logic                                AMCI_READ,
  input  logic [AXI_DATA_WIDTH-1:0]           AMCI_RDATA,
  input  logic [1:0]                          AMCI_RRESP,
  input  logic                                AMCI_RIDLE
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round-robin pick: the first requesting index after 'last', wrapping around.
  // The caller only uses the result when at least one request bit is set.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] pick;
    logic          found;
    logic [IW:0]   cand;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        pick  = cand[IW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------- write
  state_t                    w_state_r, w_state_s;
  logic [IW-1:0]             w_grant_r, w_grant_s;
  logic [IW-1:0]             w_last_r, w_last_s;
  logic [IW-1:0]             w_pick_s;
  logic                      w_pulse_s;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_s;
  logic [AXI_DATA_WIDTH-1:0] w_data_s;
  logic [2:0]                w_size_s;
  logic [NUM_REQ-1:0]        w_done_s;
  logic [1:0]                w_resp_s;

  assign w_pick_s = rr_pick(req_wreq, w_last_r);

  // Write channel next-state and next-output logic
  always_comb begin
    w_state_s = w_state_r;
    w_grant_s = w_grant_r;
    w_last_s  = w_last_r;
    w_pulse_s = 1'b0;
    w_addr_s  = AMCI_WADDR;
    w_data_s  = AMCI_WDATA;
    w_size_s  = AMCI_WSIZE;
    w_done_s  = '0;
    w_resp_s  = req_wresp;
    case (w_state_r)
      ST_IDLE: begin
        if ((|req_wreq) && AMCI_WIDLE) begin
          w_grant_s = w_pick_s;
          w_last_s  = w_pick_s;
          w_pulse_s = 1'b1;
          w_addr_s  = req_waddr[int'(w_pick_s)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          w_data_s  = req_wdata[int'(w_pick_s)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          w_size_s  = req_wsize[int'(w_pick_s)*3 +: 3];
          w_state_s = ST_WAIT;
        end else begin
          w_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // The command pulse must be gone before idle can mean "finished".
        if (!AMCI_WRITE && AMCI_WIDLE) begin
          w_done_s[w_grant_r] = 1'b1;
          w_resp_s            = AMCI_WRESP;
          w_state_s           = ST_DONE;
        end else begin
          w_state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Requests are not sampled here, so the requester has one cycle to drop its request.
        w_state_s = ST_IDLE;
      end
      default: begin
        w_state_s = ST_IDLE;
      end
    endcase
  end

  // Write channel state and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_r  <= ST_IDLE;
      w_grant_r  <= '0;
      w_last_r   <= LAST_INIT;
      AMCI_WRITE <= 1'b0;
      AMCI_WADDR <= '0;
      AMCI_WDATA <= '0;
      AMCI_WSIZE <= 3'd0;
      req_wdone  <= '0;
      req_wresp  <= 2'd0;
    end else begin
      w_state_r  <= w_state_s;
      w_grant_r  <= w_grant_s;
      w_last_r   <= w_last_s;
      AMCI_WRITE <= w_pulse_s;
      AMCI_WADDR <= w_addr_s;
      AMCI_WDATA <= w_data_s;
      AMCI_WSIZE <= w_size_s;
      req_wdone  <= w_done_s;
      req_wresp  <= w_resp_s;
    end
  end

  // ----------------------------------------------------------------- read
  state_t                    r_state_r, r_state_s;
  logic [IW-1:0]             r_grant_r, r_grant_s;
  logic [IW-1:0]             r_last_r, r_last_s;
  logic [IW-1:0]             r_pick_s;
  logic                      r_pulse_s;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_s;
  logic [2:0]                r_size_s;
  logic [NUM_REQ-1:0]        r_done_s;
  logic [AXI_DATA_WIDTH-1:0] r_data_s;
  logic [1:0]                r_resp_s;

  assign r_pick_s = rr_pick(req_rreq, r_last_r);

  // Read channel next-state and next-output logic
  always_comb begin
    r_state_s = r_state_r;
    r_grant_s = r_grant_r;
    r_last_s  = r_last_r;
    r_pulse_s = 1'b0;
    r_addr_s  = AMCI_RADDR;
    r_size_s  = AMCI_RSIZE;
    r_done_s  = '0;
    r_data_s  = req_rdata;
    r_resp_s  = req_rresp;
    case (r_state_r)
      ST_IDLE: begin
        if ((|req_rreq) && AMCI_RIDLE) begin
          r_grant_s = r_pick_s;
          r_last_s  = r_pick_s;
          r_pulse_s = 1'b1;
          r_addr_s  = req_raddr[int'(r_pick_s)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          r_size_s  = req_rsize[int'(r_pick_s)*3 +: 3];
          r_state_s = ST_WAIT;
        end else begin
          r_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!AMCI_READ && AMCI_RIDLE) begin
          r_done_s[r_grant_r] = 1'b1;
          r_data_s            = AMCI_RDATA;
          r_resp_s            = AMCI_RRESP;
          r_state_s           = ST_DONE;
        end else begin
          r_state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        r_state_s = ST_IDLE;
      end
      default: begin
        r_state_s = ST_IDLE;
      end
    endcase
  end

  // Read channel state and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_r  <= ST_IDLE;
      r_grant_r  <= '0;
      r_last_r   <= LAST_INIT;
      AMCI_READ  <= 1'b0;
      AMCI_RADDR <= '0;
      AMCI_RSIZE <= 3'd0;
      req_rdone  <= '0;
      req_rdata  <= '0;
      req_rresp  <= 2'd0;
    end else begin
      r_state_r  <= r_state_s;
      r_grant_r  <= r_grant_s;
      r_last_r   <= r_last_s;
      AMCI_READ  <= r_pulse_s;
      AMCI_RADDR <= r_addr_s;
      AMCI_RSIZE <= r_size_s;
      req_rdone  <= r_done_s;
      req_rdata  <= r_data_s;
      req_rresp  <= r_resp_s;
    end
  end

endmodule

// File: tb/tb_amci_arbiter.sv
// Directed testbench for amci_arbiter (NUM_REQ=2). A small AMCI master model
// drops idle after each command. It returns idle 3 cycles later for writes
// and 4 cycles later for reads, and then presents a response chosen by the test.
module tb_amci_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req_wreq = '0;
  logic [N*AW-1:0] req_waddr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*3-1:0]  req_wsize = '0;
  logic [N-1:0]    req_wdone;
  logic [1:0]      req_wresp;
  logic [N-1:0]    req_rreq = '0;
  logic [N*AW-1:0] req_raddr = '0;
  logic [N*3-1:0]  req_rsize = '0;
  logic [N-1:0]    req_rdone;
  logic [DW-1:0]   req_rdata;
  logic [1:0]      req_rresp;
  logic [AW-1:0]   amci_waddr;
  logic [DW-1:0]   amci_wdata;
  logic [2:0]      amci_wsize;
  logic            amci_write;
  logic [1:0]      amci_wresp;
  logic            amci_widle;
  logic [AW-1:0]   amci_raddr;
  logic [2:0]      amci_rsize;
  logic            amci_read;
  logic [DW-1:0]   amci_rdata;
  logic [1:0]      amci_rresp;
  logic            amci_ridle;

  // values the master model returns on completion
  logic [1:0]      bresp_val = 2'd0;
  logic [DW-1:0]   rdata_val = 32'h0;
  logic [1:0]      rresp_val = 2'd0;
  logic [1:0]      w_cnt;
  logic [1:0]      r_cnt;

  int n_pass  = 0;
  int n_total = 0;

  amci_arbiter #(.NUM_REQ(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .req_wreq(req_wreq), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wsize(req_wsize), .req_wdone(req_wdone), .req_wresp(req_wresp),
    .req_rreq(req_rreq), .req_raddr(req_raddr), .req_rsize(req_rsize),
    .req_rdone(req_rdone), .req_rdata(req_rdata), .req_rresp(req_rresp),
    .AMCI_WADDR(amci_waddr), .AMCI_WDATA(amci_wdata), .AMCI_WSIZE(amci_wsize),
    .AMCI_WRITE(amci_write), .AMCI_WRESP(amci_wresp), .AMCI_WIDLE(amci_widle),
    .AMCI_RADDR(amci_raddr), .AMCI_RSIZE(amci_rsize), .AMCI_READ(amci_read),
    .AMCI_RDATA(amci_rdata), .AMCI_RRESP(amci_rresp), .AMCI_RIDLE(amci_ridle)
  );

  always #5 clk = ~clk;

  // AMCI master model, write side: busy for three cycles after each command
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amci_widle <= 1'b1; w_cnt <= 2'd0; amci_wresp <= 2'd0;
    end else if (amci_write) begin
      amci_widle <= 1'b0; w_cnt <= 2'd2;
    end else if (w_cnt != 2'd0) begin
      w_cnt <= w_cnt - 2'd1;
      if (w_cnt == 2'd1) begin amci_widle <= 1'b1; amci_wresp <= bresp_val; end
    end
  end

  // AMCI master model, read side: busy for four cycles after each command
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amci_ridle <= 1'b1; r_cnt <= 2'd0; amci_rdata <= '0; amci_rresp <= 2'd0;
    end else if (amci_read) begin
      amci_ridle <= 1'b0; r_cnt <= 2'd3;
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
      if (r_cnt == 2'd1) begin
        amci_ridle <= 1'b1; amci_rdata <= rdata_val; amci_rresp <= rresp_val;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " AMCI_WRITE"}, 64'(amci_write), 64'd0);
    chk({tag, " AMCI_WADDR"}, 64'(amci_waddr), 64'd0);
    chk({tag, " AMCI_WDATA"}, 64'(amci_wdata), 64'd0);
    chk({tag, " AMCI_READ"},  64'(amci_read),  64'd0);
    chk({tag, " AMCI_RADDR"}, 64'(amci_raddr), 64'd0);
    chk({tag, " wdone"},      64'(req_wdone),  64'd0);
    chk({tag, " rdone"},      64'(req_rdone),  64'd0);
    chk({tag, " rdata"},      64'(req_rdata),  64'd0);
    chk({tag, " rresp"},      64'(req_rresp),  64'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  // wait (bounded) for an AMCI_WRITE pulse and check its address
  task automatic wait_wpulse(input string tag, input logic [AW-1:0] exp_addr);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (amci_write) break;
    end
    chk({tag, " pulse"}, 64'(amci_write), 64'd1);
    chk({tag, " addr"},  64'(amci_waddr), 64'(exp_addr));
  endtask

  // wait (bounded) for a write completion and check which requester got it
  task automatic wait_w(input string tag, input logic [N-1:0] exp);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_wdone != '0) break;
    end
    chk(tag, 64'(req_wdone), 64'(exp));
  endtask

  task automatic wait_r(input string tag, input logic [N-1:0] exp);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_rdone != '0) break;
    end
    chk(tag, 64'(req_rdone), 64'(exp));
  endtask

  initial begin
    // ---- reset state
    repeat (2) tick();
    chk_zero("reset");
    do_reset();

    // ---- 1: single write from requester 0
    req_waddr = {32'h0, 32'h0000_1000};
    req_wdata = {32'h0, 32'hDEAD_BEEF};
    req_wsize = {3'd0, 3'd2};
    req_wreq  = 2'b01;
    tick();
    chk("t1 AMCI_WRITE c1", 64'(amci_write), 64'd1);
    chk("t1 WADDR", 64'(amci_waddr), 64'h1000);
    chk("t1 WDATA", 64'(amci_wdata), 64'hDEAD_BEEF);
    chk("t1 WSIZE", 64'(amci_wsize), 64'd2);
    tick();
    chk("t1 AMCI_WRITE c2", 64'(amci_write), 64'd0);
    tick();
    tick();
    chk("t1 wdone early", 64'(req_wdone), 64'd0);
    tick();
    chk("t1 wdone", 64'(req_wdone), 64'b01);
    chk("t1 wresp", 64'(req_wresp), 64'd0);
    req_wreq = 2'b00;
    tick();
    chk("t1 wdone width", 64'(req_wdone), 64'd0);

    // ---- 2: contention, both held, grants 0,1,0,1
    do_reset();
    req_waddr = {32'h0000_00A1, 32'h0000_00A0};
    req_wreq  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_wpulse($sformatf("t2 grant%0d", k), (k % 2 == 1) ? 32'hA1 : 32'hA0);
      wait_w($sformatf("t2 done%0d", k), (k % 2 == 1) ? 2'b10 : 2'b01);
    end
    req_wreq = 2'b00;
    tick();

    // ---- 3: concurrent read (req 0) and write (req 1)
    rdata_val = 32'h1234_5678;
    rresp_val = 2'd0;
    req_raddr = {32'h0, 32'h0000_2000};
    req_rsize = {3'd0, 3'd2};
    req_waddr = {32'h0000_3000, 32'h0};
    req_wdata = {32'h5555_AAAA, 32'h0};
    req_rreq  = 2'b01;
    req_wreq  = 2'b10;
    tick();
    chk("t3 AMCI_READ", 64'(amci_read), 64'd1);
    chk("t3 AMCI_WRITE", 64'(amci_write), 64'd1);
    chk("t3 RADDR", 64'(amci_raddr), 64'h2000);
    chk("t3 RSIZE", 64'(amci_rsize), 64'd2);
    chk("t3 WADDR", 64'(amci_waddr), 64'h3000);
    chk("t3 WDATA", 64'(amci_wdata), 64'h5555_AAAA);
    wait_w("t3 wdone", 2'b10);
    req_wreq = 2'b00;
    wait_r("t3 rdone", 2'b01);
    chk("t3 rdata", 64'(req_rdata), 64'h1234_5678);
    chk("t3 rresp", 64'(req_rresp), 64'd0);
    req_rreq = 2'b00;
    tick();

    // ---- 4: read error from requester 1
    rdata_val = 32'h0BAD_F00D;
    rresp_val = 2'd2;
    req_raddr = {32'h0000_2400, 32'h0};
    req_rreq  = 2'b10;
    tick();
    chk("t4 RADDR", 64'(amci_raddr), 64'h2400);
    wait_r("t4 rdone", 2'b10);
    chk("t4 rresp", 64'(req_rresp), 64'd2);
    chk("t4 rdata", 64'(req_rdata), 64'h0BAD_F00D);
    req_rreq = 2'b00;
    tick();

    // ---- 5: requester 0 pulses its request while req 1's write is in WAIT
    req_waddr = {32'h0000_3100, 32'h0000_0F00};
    req_wreq  = 2'b10;
    wait_wpulse("t5 grant1", 32'h3100);
    req_wreq = 2'b11;
    tick();
    req_wreq = 2'b10;
    wait_w("t5 wdone", 2'b10);
    req_wreq = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t5 no write %0d", k), 64'(amci_write), 64'd0);
      chk($sformatf("t5 no done %0d", k), 64'(req_wdone), 64'd0);
    end

    // ---- 6: reset while in WAIT
    req_waddr = {32'h0000_4100, 32'h0000_4000};
    req_wreq  = 2'b01;
    wait_wpulse("t6 grant0", 32'h4000);
    tick();
    resetn = 1'b0;
    #1;
    chk_zero("t6 async");
    tick();
    tick();
    tick();
    chk_zero("t6 held");
    req_wreq = 2'b11;
    resetn   = 1'b1;
    wait_wpulse("t6 first after reset", 32'h4000);
    wait_w("t6 wdone", 2'b01);
    req_wreq = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
